wb_cmd_master: RTL and testbench

Wishbone B4 pipelined single-beat bus master that converts a simple valid/ready command stream into one bus transaction per command and returns one response per command. It sits directly upstream of the Wishbone slaves in the design, such as the LED/memory register slave, and drives their cyc/stb/we/addr/data/sel inputs. It terminates every transaction on ack, err or a bounded timeout, so a missing or hung slave can never lock the command source.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_cmd_master.sv | 137 +++++++++++++
 tb/tb_wb_cmd_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the bus masters and slaves in this design.
package wb_pkg;

    localparam int WB_ADDR_W = 30;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    // Single-beat pipelined master: idle, strobing, waiting for ack/err.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } wb_mstate_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone B4 pipelined single-beat master: one bus transaction and one
// response per accepted command. Every transaction ends on ack, err or a
// bounded timeout so a dead slave cannot wedge the command source.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [WB_ADDR_W-1:0] i_cmd_addr,
    input  logic [WB_DATA_W-1:0] i_cmd_data,
    input  logic [WB_SEL_W-1:0]  i_cmd_sel,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [WB_ADDR_W-1:0] o_wb_addr,
    output logic [WB_DATA_W-1:0] o_wb_data,
    output logic [WB_SEL_W-1:0]  o_wb_sel,
    input  logic                 i_wb_stall,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err,
    input  logic [WB_DATA_W-1:0] i_wb_data,
    output logic                 o_rsp_valid,
    output logic [WB_DATA_W-1:0] o_rsp_data,
    output logic                 o_rsp_err,
    output logic                 o_rsp_timeout,
    output logic                 o_busy
);

    wb_mstate_t            state_q, state_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  we_q;
    logic [WB_ADDR_W-1:0]  addr_q;
    logic [WB_DATA_W-1:0]  wdata_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WB_DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_to_q, rsp_to_d;
    logic                  accept;
    logic                  to_hit;

    assign accept = (state_q == IDLE) && i_cmd_valid;
    // Counter is 0 in the first stb cycle, so this fires TIMEOUT cycles in.
    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Next state, timeout count and the response to publish next cycle.
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    state_d  = REQ;
                    to_cnt_d = '0;
                end
            end
            REQ, WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // ack/err win over the timeout and also end a stalled REQ.
                if (i_wb_ack || i_wb_err) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = i_wb_err;
                    rsp_to_d    = 1'b0;
                    rsp_data_d  = (i_wb_ack && !i_wb_err && !we_q) ? i_wb_data : '0;
                end else if (to_hit) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_data_d  = '0;
                end else if (state_q == REQ && !i_wb_stall) begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, timeout counter and response registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    // Bus request fields: loaded on accept, held after completion.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
        end else if (accept) begin
            we_q    <= i_cmd_we;
            addr_q  <= i_cmd_addr;
            wdata_q <= i_cmd_data;
            sel_q   <= i_cmd_sel;
        end
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_wb_cyc      = (state_q != IDLE);
    assign o_wb_stb      = (state_q == REQ);
    assign o_wb_we       = we_q;
    assign o_wb_addr     = addr_q;
    assign o_wb_data     = wdata_q;
    assign o_wb_sel      = sel_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed scenarios plus randomized traffic, with a
// transaction-level model checked against the DUT on every falling edge.
module tb_wb_cmd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_we;
    logic [29:0] i_cmd_addr;
    logic [31:0] i_cmd_data;
    logic [3:0]  i_cmd_sel;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall, i_wb_ack, i_wb_err;
    logic [31:0] i_wb_data;
    logic        o_rsp_valid, o_rsp_err, o_rsp_timeout, o_busy;
    logic [31:0] o_rsp_data;

    wb_cmd_master #(.TIMEOUT(TO), .TO_W(16)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_sel(i_cmd_sel),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_wb_data(i_wb_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model + monitor ----------------
    int          ncyc = 0;
    logic        m_act = 1'b0, m_stb = 1'b0, m_rsp = 1'b0;
    int          m_age = 0;
    logic        m_we = 1'b0;
    logic [29:0] m_addr = '0;
    logic [31:0] m_wdat = '0;
    logic [3:0]  m_sel = '0;
    logic        e_err = 1'b0, e_to = 1'b0;
    logic [31:0] e_data = '0;

    int          acc_cyc = 0, rsp_cyc = 0, stb_cnt = 0, rsp_cnt = 0;
    logic [31:0] rsp_d = '0;
    logic        rsp_e = 1'b0, rsp_t = 1'b0;
    int          acc_q[$];

    always @(negedge clk) begin
        ncyc++;
        if (o_wb_stb) stb_cnt++;
        if (o_rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = ncyc;
            rsp_d = o_rsp_data;
            rsp_e = o_rsp_err;
            rsp_t = o_rsp_timeout;
        end
        if (!rst && i_cmd_valid && o_cmd_ready) begin
            acc_cyc = ncyc;
            stb_cnt = 0;
            acc_q.push_back(ncyc);
        end
        if (rst) begin
            chk("rst_ready", 32'(o_cmd_ready), 32'd1);
            chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
            chk("rst_stb", 32'(o_wb_stb), 32'd0);
            chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_addr", 32'(o_wb_addr), 32'd0);
            m_act = 0; m_stb = 0; m_rsp = 0; m_age = 0;
            m_we = 0; m_addr = '0; m_wdat = '0; m_sel = '0;
        end else begin
            chk("ready", 32'(o_cmd_ready), 32'(!m_act));
            chk("busy", 32'(o_busy), 32'(m_act));
            chk("cyc", 32'(o_wb_cyc), 32'(m_act));
            chk("stb", 32'(o_wb_stb), 32'(m_stb));
            chk("wb_we", 32'(o_wb_we), 32'(m_we));
            chk("wb_addr", 32'(o_wb_addr), 32'(m_addr));
            chk("wb_data", o_wb_data, m_wdat);
            chk("wb_sel", 32'(o_wb_sel), 32'(m_sel));
            chk("rsp_valid", 32'(o_rsp_valid), 32'(m_rsp));
            if (m_rsp) begin
                chk("rsp_err", 32'(o_rsp_err), 32'(e_err));
                chk("rsp_timeout", 32'(o_rsp_timeout), 32'(e_to));
                chk("rsp_data", o_rsp_data, e_data);
            end
            // advance the model with this cycle's inputs
            m_rsp = 1'b0;
            if (!m_act) begin
                if (i_cmd_valid) begin
                    m_act = 1; m_stb = 1; m_age = 1;
                    m_we = i_cmd_we; m_addr = i_cmd_addr;
                    m_wdat = i_cmd_data; m_sel = i_cmd_sel;
                end
            end else if (i_wb_ack || i_wb_err) begin
                m_act = 0; m_stb = 0; m_rsp = 1;
                e_err = i_wb_err; e_to = 0;
                e_data = (i_wb_ack && !i_wb_err && !m_we) ? i_wb_data : 32'd0;
            end else if (m_age == TO) begin
                m_act = 0; m_stb = 0; m_rsp = 1;
                e_err = 1; e_to = 1; e_data = 32'd0;
            end else begin
                if (!i_wb_stall) m_stb = 0;
                m_age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_cmd_valid = 0; i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0;
    endtask

    task automatic put_cmd(input logic we, input logic [29:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        i_cmd_valid = 1; i_cmd_we = we; i_cmd_addr = a; i_cmd_data = d; i_cmd_sel = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int   r0, a0, k;
    logic acc, silent;

    initial begin
        rst = 1;
        idle_in();
        i_cmd_we = 0; i_cmd_addr = '0; i_cmd_data = '0; i_cmd_sel = '0; i_wb_data = '0;
        silent = 0;
        #1;
        chk("reset_ready", 32'(o_cmd_ready), 32'd1);
        chk("reset_cyc", 32'(o_wb_cyc), 32'd0);
        repeat (3) step();
        rst = 0;
        step(); step();

        // write, zero stall, ack one cycle after stb
        put_cmd(1, 30'd0, 32'h0000_00A5, 4'hF); step();
        i_cmd_valid = 0; step();
        i_wb_ack = 1; step();
        i_wb_ack = 0; step(); step();
        chk("t1_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
        chk("t1_stb_cycles", 32'(stb_cnt), 32'd1);
        chk("t1_err", 32'(rsp_e), 32'd0);
        chk("t1_data", rsp_d, 32'd0);
        chk("t1_wb_data", o_wb_data, 32'h0000_00A5);

        // read with 4 stall cycles
        r0 = rsp_cnt;
        put_cmd(0, 30'd3, 32'h0, 4'hF); step();
        i_cmd_valid = 0; i_wb_stall = 1; repeat (4) step();
        i_wb_stall = 0; step();
        i_wb_ack = 1; i_wb_data = 32'h0000_0040; step();
        i_wb_ack = 0; step(); step();
        chk("t2_stb_cycles", 32'(stb_cnt), 32'd5);
        chk("t2_data", rsp_d, 32'h0000_0040);
        chk("t2_latency", 32'(rsp_cyc - acc_cyc), 32'd7);
        chk("t2_count", 32'(rsp_cnt - r0), 32'd1);

        // ack while stalled in the first stb cycle
        r0 = rsp_cnt;
        put_cmd(0, 30'd5, 32'h0, 4'h3); step();
        i_cmd_valid = 0; i_wb_stall = 1; i_wb_ack = 1; i_wb_data = 32'h1234_5678; step();
        i_wb_stall = 0; i_wb_ack = 0;
        chk("t3_cyc_drop", 32'(o_wb_cyc), 32'd0);
        step(); step(); step();
        chk("t3_count", 32'(rsp_cnt - r0), 32'd1);
        chk("t3_err", 32'(rsp_e), 32'd0);
        chk("t3_data", rsp_d, 32'h1234_5678);
        chk("t3_latency", 32'(rsp_cyc - acc_cyc), 32'd2);

        // err and ack together
        put_cmd(0, 30'd7, 32'h0, 4'hF); step();
        i_cmd_valid = 0; i_wb_ack = 1; i_wb_err = 1; i_wb_data = 32'hFFFF_FFFF; step();
        i_wb_ack = 0; i_wb_err = 0; step(); step();
        chk("t4_err", 32'(rsp_e), 32'd1);
        chk("t4_data", rsp_d, 32'd0);
        chk("t4_timeout", 32'(rsp_t), 32'd0);

        // silent slave -> timeout
        put_cmd(1, 30'd9, 32'hDEAD_BEEF, 4'hF); step();
        i_cmd_valid = 0; repeat (12) step();
        chk("t5_latency", 32'(rsp_cyc - acc_cyc), 32'd9);
        chk("t5_err", 32'(rsp_e), 32'd1);
        chk("t5_timeout", 32'(rsp_t), 32'd1);
        chk("t5_data", rsp_d, 32'd0);
        chk("t5_cyc", 32'(o_wb_cyc), 32'd0);

        // reset two cycles after stb
        r0 = rsp_cnt;
        put_cmd(0, 30'd11, 32'h0, 4'hF); step();
        i_cmd_valid = 0; step();
        step();
        rst = 1; #1;
        chk("t6_async_cyc", 32'(o_wb_cyc), 32'd0);
        step(); step();
        rst = 0; i_wb_ack = 1; step();
        i_wb_ack = 0; step(); step();
        chk("t6_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        put_cmd(0, 30'd12, 32'h0, 4'hF); step();
        i_cmd_valid = 0; step();
        i_wb_ack = 1; i_wb_data = 32'h0000_CAFE; step();
        i_wb_ack = 0; step(); step();
        chk("t6_after_latency", 32'(rsp_cyc - acc_cyc), 32'd3);
        chk("t6_after_data", rsp_d, 32'h0000_CAFE);
        chk("t6_after_count", 32'(rsp_cnt - r0), 32'd1);

        // back-to-back, four commands held valid continuously
        a0 = acc_q.size(); r0 = rsp_cnt; k = 0;
        for (int c = 0; c < 30; c++) begin
            if (k < 4) put_cmd(k % 2 == 1, 30'(20 + k), 32'h1000 + 32'(k), 4'hF);
            else i_cmd_valid = 0;
            i_wb_stall = 0;
            i_wb_ack = o_wb_cyc && !o_wb_stb;
            i_wb_data = 32'hD000_0000 + 32'(c);
            acc = o_cmd_ready && i_cmd_valid;
            step();
            if (acc) k++;
        end
        idle_in();
        chk("t7_accepts", 32'(acc_q.size() - a0), 32'd4);
        chk("t7_rsps", 32'(rsp_cnt - r0), 32'd4);
        if (acc_q.size() - a0 == 4)
            for (int i = 0; i < 3; i++)
                chk("t7_spacing", 32'(acc_q[a0 + i + 1] - acc_q[a0 + i]), 32'd3);

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 9) < 7)
                put_cmd(1'($urandom_range(0, 1)), 30'($urandom), $urandom, 4'($urandom));
            else
                i_cmd_valid = 0;
            i_wb_data = $urandom;
            if (o_wb_cyc) begin
                i_wb_stall = ($urandom_range(0, 9) < 3);
                i_wb_ack = !silent && ($urandom_range(0, 9) < 3);
                i_wb_err = !silent && ($urandom_range(0, 9) == 0);
            end else begin
                i_wb_stall = ($urandom_range(0, 1) == 0);
                i_wb_ack = ($urandom_range(0, 4) == 0);
                i_wb_err = ($urandom_range(0, 4) == 0);
            end
            acc = o_cmd_ready && i_cmd_valid;
            step();
            if (acc) silent = ($urandom_range(0, 6) == 0);
        end
        idle_in();
        repeat (15) step();
        // one accept was aborted by reset and never answered
        chk("final_rsp_per_accept", 32'(rsp_cnt), 32'(acc_q.size() - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
